// File: rtl/hpc_pkg.sv
// Shared constants for the multi-channel toggle-handshake source controller.
package hpc_pkg;

    // Per-channel FSM encoding
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Supported depth of the ack synchronizer
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    // Largest backlog a CNT_W-bit pending counter can hold
    function automatic int max_count(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/hpc_src_chan.sv
// One source-side channel: ack synchronizer, toggle-request FSM,
// pending-pulse backlog counter and sticky overflow flag.
module hpc_src_chan
    import hpc_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_MODE   = 0
) (
    input  logic             src_clkA,
    input  logic             rstA,
    input  logic             sinput,
    input  logic             ack_in,
    input  logic             ovf_clr,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(max_count(CNT_W));
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
    localparam bit               DROP     = (DROP_MODE != 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   state_q, state_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic                   ovf_q, ovf_d;

    logic ack_s;
    logic mismatch;
    logic in_wait;
    logic has_pend;
    logic ovf_set;

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign mismatch = ack_s ^ req_q;
    // A mismatch while nominally idle (stale ack after reset) is treated as
    // an in-flight transfer, so the channel cannot launch until ack realigns.
    assign in_wait  = (state_q == ST_WAIT) | mismatch;
    assign has_pend = (pend_q != '0);

    // Next-state: synchronizer shift, launch/complete, backlog and overflow
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ack_in};
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (!in_wait) begin
            if (sinput | has_pend) begin
                req_d   = ~req_q;
                state_d = ST_WAIT;
                // A fresh pulse alongside a backlog is one out, one in
                if (!sinput) pend_d = pend_q - PEND_ONE;
            end
        end else begin
            state_d = mismatch ? ST_WAIT : ST_IDLE;
            if (sinput) begin
                if (DROP || (pend_q == PEND_MAX)) ovf_set = 1'b1;
                else                               pend_d = pend_q + PEND_ONE;
            end
        end
        if (DROP) pend_d = '0;
        // Set beats clear when both land in the same cycle
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    // Channel state registers
    always_ff @(posedge src_clkA or negedge rstA) begin
        if (!rstA) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_out  = req_q;
    assign busy     = in_wait | has_pend;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/hpc_multi_src.sv
// Multi-channel toggle-handshake pulse source: NCH independent channels.
module hpc_multi_src
    import hpc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_MODE   = 0
) (
    input  logic                 src_clkA,
    input  logic                 rstA,
    input  logic [NCH-1:0]       sinput,
    input  logic [NCH-1:0]       ack_in,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH-1:0]       req_out,
    output logic [NCH-1:0]       busy,
    output logic [NCH*CNT_W-1:0] pending,
    output logic [NCH-1:0]       overflow
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("hpc_multi_src: SYNC_STAGES outside supported range");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        hpc_src_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .DROP_MODE   (DROP_MODE)
        ) u_chan (
            .src_clkA (src_clkA),
            .rstA     (rstA),
            .sinput   (sinput[i]),
            .ack_in   (ack_in[i]),
            .ovf_clr  (ovf_clr[i]),
            .req_out  (req_out[i]),
            .busy     (busy[i]),
            .pending  (pending[i*CNT_W +: CNT_W]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_hpc_multi_src.sv
// Bench for hpc_multi_src: a queue-mode and a drop-mode instance share
// stimulus; each is echoed by a delayed destination and checked every cycle.
module tb_hpc_multi_src;

    localparam int NCH   = 4;
    localparam int CNT_W = 3;
    localparam int SYNC  = 2;
    localparam int PMAX  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] sin = '0;
    logic [NCH-1:0] clr = '0;
    logic [NCH-1:0] ack [2];
    logic [NCH-1:0] req_o [2];
    logic [NCH-1:0] busy_o [2];
    logic [NCH-1:0] ovf_o [2];
    logic [NCH*CNT_W-1:0] pend_o [2];

    hpc_multi_src #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .DROP_MODE(0)) u_q (
        .src_clkA(clk), .rstA(rst_n), .sinput(sin), .ack_in(ack[0]), .ovf_clr(clr),
        .req_out(req_o[0]), .busy(busy_o[0]), .pending(pend_o[0]), .overflow(ovf_o[0]));

    hpc_multi_src #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .DROP_MODE(1)) u_d (
        .src_clkA(clk), .rstA(rst_n), .sinput(sin), .ack_in(ack[1]), .ovf_clr(clr),
        .req_out(req_o[1]), .busy(busy_o[1]), .pending(pend_o[1]), .overflow(ovf_o[1]));

    always #5 clk = ~clk;

    // Reference state per [dut][channel]: index 0 = queue mode, 1 = drop mode
    int m_req  [2][NCH];
    int m_wait [2][NCH];
    int m_pend [2][NCH];
    int m_ovf  [2][NCH];
    int hist   [2][NCH][SYNC];   // ack samples as seen through the synchronizer
    int reqh   [2][NCH][32];     // req history for the echoing destination
    int dly    [NCH];
    int frc_en [NCH];
    int frc_val[NCH];
    int tog    [2][NCH];
    logic [NCH-1:0] prev_req [2];
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int ch = 0; ch < NCH; ch++) begin
                m_req[m][ch] = 0; m_wait[m][ch] = 0; m_pend[m][ch] = 0; m_ovf[m][ch] = 0;
                for (int k = 0; k < SYNC; k++) hist[m][ch][k] = 0;
                for (int k = 0; k < 32; k++) reqh[m][ch][k] = 0;
            end
    endtask

    // One clock edge of the behaviour: idle channels launch, busy ones queue or lose
    task automatic model_step(input int m, input logic [NCH-1:0] s, input logic [NCH-1:0] c,
                              input logic [NCH-1:0] a);
        for (int ch = 0; ch < NCH; ch++) begin
            bit mis, waiting, lost;
            mis = (hist[m][ch][SYNC-1] != m_req[m][ch]);
            waiting = (m_wait[m][ch] != 0) || mis;
            lost = 1'b0;
            if (!waiting) begin
                if (s[ch] || m_pend[m][ch] > 0) begin
                    m_req[m][ch] ^= 1;
                    m_wait[m][ch] = 1;
                    if (!s[ch]) m_pend[m][ch]--;
                end
            end else begin
                m_wait[m][ch] = mis ? 1 : 0;
                if (s[ch]) begin
                    if (m == 1 || m_pend[m][ch] == PMAX) lost = 1'b1;
                    else m_pend[m][ch]++;
                end
            end
            if (lost) m_ovf[m][ch] = 1;
            else if (c[ch]) m_ovf[m][ch] = 0;
            for (int k = SYNC-1; k > 0; k--) hist[m][ch][k] = hist[m][ch][k-1];
            hist[m][ch][0] = a[ch];
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    task automatic compare();
        logic [NCH-1:0] er, eb, eo;
        logic [NCH*CNT_W-1:0] ep;
        for (int m = 0; m < 2; m++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                er[ch] = m_req[m][ch][0];
                eb[ch] = (m_wait[m][ch] != 0) || (hist[m][ch][SYNC-1] != m_req[m][ch])
                         || (m_pend[m][ch] != 0);
                eo[ch] = m_ovf[m][ch][0];
                ep[ch*CNT_W +: CNT_W] = m_pend[m][ch][CNT_W-1:0];
                if (rst_n && req_o[m][ch] != prev_req[m][ch]) tog[m][ch]++;
            end
            prev_req[m] = req_o[m];
            check($sformatf("dut%0d req_out", m),  int'(req_o[m]),  int'(er));
            check($sformatf("dut%0d busy", m),     int'(busy_o[m]), int'(eb));
            check($sformatf("dut%0d pending", m),  int'(pend_o[m]), int'(ep));
            check($sformatf("dut%0d overflow", m), int'(ovf_o[m]),  int'(eo));
        end
    endtask

    task automatic drive_step(input logic [NCH-1:0] s, input logic [NCH-1:0] c);
        logic [NCH-1:0] a [2];
        for (int m = 0; m < 2; m++)
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 31; k > 0; k--) reqh[m][ch][k] = reqh[m][ch][k-1];
                reqh[m][ch][0] = m_req[m][ch];
                a[m][ch] = (frc_en[ch] != 0) ? frc_val[ch][0] : reqh[m][ch][dly[ch]][0];
            end
        sin = s; clr = c; ack[0] = a[0]; ack[1] = a[1];
        if (rst_n) begin
            model_step(0, s, c, a[0]);
            model_step(1, s, c, a[1]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic cyc(input logic [NCH-1:0] s, input logic [NCH-1:0] c);
        tick();
        drive_step(s, c);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, '0);
    endtask

    task automatic do_reset(input int n);
        tick();
        rst_n = 1'b0;
        model_reset();
        drive_step('0, '0);
        repeat (n) begin tick(); drive_step('0, '0); end
        for (int m = 0; m < 2; m++) begin
            check($sformatf("reset dut%0d req_out", m),  int'(req_o[m]),  0);
            check($sformatf("reset dut%0d pending", m),  int'(pend_o[m]), 0);
            check($sformatf("reset dut%0d overflow", m), int'(ovf_o[m]),  0);
        end
        tick();
        rst_n = 1'b1;
        drive_step('0, '0);
    endtask

    initial begin
        int b0, b1, r;
        bit found;
        model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            dly[ch] = 3; frc_en[ch] = 0; frc_val[ch] = 0;
            tog[0][ch] = 0; tog[1][ch] = 0;
        end
        prev_req[0] = '0; prev_req[1] = '0;
        drive_step('0, '0);
        do_reset(2);
        check("reset busy q", int'(busy_o[0]), 0);

        // Single pulse on ch0, destination echoes after 3 cycles
        b0 = tog[0][0];
        cyc(4'b0001, '0);
        idle(1);
        check("single req_out[0]", int'(req_o[0][0]), 1);
        check("single busy[0]", int'(busy_o[0][0]), 1);
        idle(15);
        check("single toggles", tog[0][0] - b0, 1);
        check("single busy end", int'(busy_o[0][0]), 0);

        // Backlog of 3 on ch1 behind a slow ack
        dly[1] = 10;
        b0 = tog[0][1];
        repeat (4) cyc(4'b0010, '0);
        idle(1);
        check("backlog pending[1]", int'(pend_o[0][CNT_W +: CNT_W]), 3);
        idle(80);
        check("backlog toggles", tog[0][1] - b0, 4);
        check("backlog busy end", int'(busy_o[0][1]), 0);

        // Saturation on ch2: 1 launch + 9 pulses in one long WAIT
        dly[2] = 20;
        b0 = tog[0][2]; b1 = tog[1][2];
        repeat (10) cyc(4'b0100, '0);
        idle(1);
        check("sat pending[2]", int'(pend_o[0][2*CNT_W +: CNT_W]), 7);
        check("sat overflow[2]", int'(ovf_o[0][2]), 1);
        idle(260);
        check("sat toggles q", tog[0][2] - b0, 8);
        check("sat toggles drop", tog[1][2] - b1, 1);
        check("sat drop pending", int'(pend_o[1][2*CNT_W +: CNT_W]), 0);
        cyc('0, 4'b0100);
        idle(1);
        check("sat ovf cleared", int'(ovf_o[0][2]), 0);

        // Drop mode: 2 extra pulses during WAIT on ch3
        dly[3] = 8;
        b0 = tog[0][3]; b1 = tog[1][3];
        repeat (3) cyc(4'b1000, '0);
        idle(60);
        check("drop toggles", tog[1][3] - b1, 1);
        check("drop overflow", int'(ovf_o[1][3]), 1);
        check("drop pending", int'(pend_o[1][3*CNT_W +: CNT_W]), 0);
        check("queue toggles ch3", tog[0][3] - b0, 3);

        // Overflow set and clear on the same cycle: set wins
        cyc(4'b1000, '0);
        cyc(4'b1000, 4'b1000);
        idle(1);
        check("set beats clear", int'(ovf_o[1][3]), 1);
        idle(30);

        // Pulse on the WAIT->IDLE cycle is queued and launched next cycle
        cyc(4'b0001, '0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_wait[0][0] != 0 && hist[0][0][SYNC-1] == m_req[0][0]) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("ack-return cycle reached", int'(found), 1);
        r = int'(req_o[0][0]);
        cyc(4'b0001, '0);
        idle(1);
        check("coincident queued", int'(pend_o[0][0 +: CNT_W]), 1);
        check("coincident no launch yet", int'(req_o[0][0]), r);
        idle(1);
        check("coincident launched", int'(req_o[0][0]), 1 - r);
        idle(20);

        // Reset mid-transfer with a stale ack held high on ch0
        cyc(4'b0001, '0);
        idle(1);
        frc_en[0] = 1; frc_val[0] = 1;
        do_reset(2);
        idle(4);
        check("stale ack busy q", int'(busy_o[0][0]), 1);
        check("stale ack busy d", int'(busy_o[1][0]), 1);
        frc_val[0] = 0;
        idle(6);
        check("stale ack cleared", int'(busy_o[0][0]), 0);
        frc_en[0] = 0;
        b0 = tog[0][0];
        cyc(4'b0001, '0);
        idle(15);
        check("post-reset toggles", tog[0][0] - b0, 1);
        check("post-reset busy", int'(busy_o[0][0]), 0);

        // Randomized traffic with varying destination latency
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] s, c;
            if (i % 250 == 0)
                for (int ch = 0; ch < NCH; ch++) dly[ch] = $urandom_range(12, 1);
            for (int ch = 0; ch < NCH; ch++) begin
                s[ch] = ($urandom_range(3) == 0);
                c[ch] = ($urandom_range(15) == 0);
            end
            cyc(s, c);
        end
        for (int ch = 0; ch < NCH; ch++) dly[ch] = 4;
        idle(300);
        check("drain busy q", int'(busy_o[0]), 0);
        check("drain busy d", int'(busy_o[1]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hpc_multi_src.md
Name: hpc_multi_src

Overview:
- Parametrised, multi-channel source-side controller for toggle-handshake pulse transfer. It is the next generation of the single-channel handshake pulse synchronizer.
- Per channel, it accepts single-cycle pulses on src_clkA and issues a toggle request toward the destination domain. It waits for the returning acknowledge, which is synchronized internally.
- Unlike the previous generation, it queues pulses that arrive while a channel is busy instead of silently dropping them. It also reports backlog and overflow.
- Sits in the source domain; pairs with a destination-side toggle detector that echoes req as ack.

Parameters:
- NCH, 4, number of independent channels.
- CNT_W, 3, pending-pulse counter width; max backlog per channel = 2^CNT_W-1.
- SYNC_STAGES, 2, flops in each ack synchronizer (legal range 2..4).
- DROP_MODE, 0, 0 = queue pulses arriving while busy; 1 = drop them (legacy behaviour) and flag overflow.

Ports:
- src_clkA  input  1  sole clock.
- rstA  input  1  asynchronous active-low reset.
- sinput  input  NCH  per-channel single-cycle event pulse, synchronous to src_clkA.
- ack_in  input  NCH  per-channel toggle acknowledge from destination domain; asynchronous.
- ovf_clr  input  NCH  per-channel pulse; clears the sticky overflow flag.
- req_out  output  NCH  per-channel toggle request level, registered.
- busy  output  NCH  channel in WAIT or pending != 0.
- pending  output  NCH*CNT_W  per-channel backlog count; channel i occupies bits [i*CNT_W +: CNT_W].
- overflow  output  NCH  sticky; set when a pulse is lost.

Behaviour:
- Clock and reset: one clock, src_clkA. Reset rstA is asynchronous and active-low.
- Reset values: req_out=0, all ack sync flops=0, pending=0, overflow=0, state=IDLE, busy=0.
- Ack synchronizer: ack_in[i] passes through SYNC_STAGES flops to give ack_s[i]. No logic precedes the first flop.
- Per-channel FSM, IDLE:
  - IDLE means no transfer in flight (ack_s == req_out).
  - If sinput=1 or pending!=0: toggle req_out and go to WAIT.
  - If the launch is served from backlog (pending!=0, sinput=0): pending decrements.
  - If pending!=0 and sinput=1 in the same cycle: pending is unchanged; the launch is counted as one out of the queue and one into it.
- Per-channel FSM, WAIT:
  - Go to IDLE on the first cycle where ack_s == req_out.
  - An sinput in WAIT is queued or dropped per the rules below.
- Latency:
  - sinput sampled at edge k; req_out toggles at edge k, visible from cycle k+1.
  - Ack returning at ack_in reaches ack_s after SYNC_STAGES edges. The FSM reaches IDLE on the following edge.
  - Back-to-back transfers: at least one IDLE cycle separates successive req_out toggles.
- Queue mode (DROP_MODE=0):
  - sinput in WAIT increments pending.
  - At pending = 2^CNT_W-1 a further pulse is lost: pending holds, overflow is set.
  - A pulse arriving on the same cycle WAIT->IDLE occurs is queued; it is launched on the next IDLE cycle.
- Drop mode (DROP_MODE=1):
  - pending is tied to 0.
  - sinput in WAIT is discarded and sets overflow.
- overflow: sticky until ovf_clr. If set and clear coincide, set wins.
- busy = (state==WAIT) | (pending!=0). It is combinational from registers only.
- Reset mid-transfer: all state returns to reset values immediately. In-flight and queued pulses are discarded. The destination side must also be reset so that ack returns to 0 and toggle phase realigns. A stale ack_in=1 after reset is treated as a mismatch: the channel is held in a synthetic WAIT until ack_s==0. Hence, after reset, state = (ack_s != req_out) ? WAIT : IDLE evaluated every cycle.
- Channels are fully independent; no arbitration between channels.

Decomposition:
- Shared package hpc_pkg:
  - FSM state encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1.
  - Max-count helper constant, 2^CNT_W-1.
  - SYNC_STAGES legal-range constants.
- Sub-module hpc_src_chan: one channel, containing the ack synchronizer, FSM, pending counter and overflow flag.
- Top level: hpc_multi_src is a generate loop of NCH instances plus port slicing.

Test Plan:
- Single pulse: sinput[0]=1 one cycle, ack_in[0] echoes req after 3 cycles (SYNC_STAGES=2) -> req_out[0] 0->1 at cycle 1. busy[0] is high from cycle 1 until ack_s matches, and low one cycle later. pending stays 0.
- Backlog: 3 pulses on ch1 while WAIT, ack delayed 10 cycles -> pending[1] reaches 3. req_out[1] toggles 3 more times, each after ack match plus one IDLE cycle. Final pending=0, busy=0.
- Saturation (CNT_W=3): 9 pulses during one long WAIT -> pending=7, overflow[2]=1. Exactly 8 total req toggles after draining. ovf_clr[2] clears overflow.
- Drop mode (DROP_MODE=1): 2 pulses during WAIT -> 1 req toggle total, overflow=1, pending=0.
- Simultaneous events: sinput coincides with WAIT->IDLE transition -> queued and launched next cycle. ovf_clr and a new overflow in the same cycle -> overflow stays 1.
- Reset mid-transfer with ack_in held at 1 -> outputs reach reset values. Channel stays busy until ack_in drops to 0 and propagates. A subsequent pulse transfers normally.
